// File: rtl/hdlc_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : hdlc_tx_pkg
// Brief  : Shared types and constants for the HDLC transmit serializer.
// Rev    : 1.0
// ============================================================================
package hdlc_tx_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FLAG_START = 3'd1,
    DATA       = 3'd2,
    FCS        = 3'd3,
    FLAG_END   = 3'd4,
    ABORT      = 3'd5
  } tx_state_t;

  localparam logic [7:0]  HDLC_FLAG     = 8'h7E;
  localparam logic [7:0]  HDLC_ABORT    = 8'hFE;
  localparam logic [15:0] FCS_POLY_REFL = 16'h8408;
  localparam logic [15:0] FCS_INIT      = 16'hFFFF;
  localparam logic [2:0]  STUFF_LIMIT   = 3'd5;

  // Run length of consecutive transmitted ones after sending bit b.
  function automatic logic [2:0] ones_next(input logic [2:0] ones, input logic b);
    return b ? (ones + 3'd1) : 3'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdlc_fcs16.sv
`default_nettype none
// ============================================================================
// Module : hdlc_fcs16
// Brief  : Bit-serial CRC-16/X.25 register; o_fcs is the complemented value.
// Rev    : 1.0
// ============================================================================
module hdlc_fcs16
  import hdlc_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic        i_bit,
  output logic [15:0] o_fcs
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[0] ^ i_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= FCS_INIT;
    end else if (i_clear) begin
      r_crc <= FCS_INIT;
    end else if (i_enable) begin
      r_crc <= (r_crc >> 1) ^ (w_fb ? FCS_POLY_REFL : 16'h0000);
    end
  end

  assign o_fcs = ~r_crc;

endmodule
`default_nettype wire

// File: rtl/hdlc_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module : hdlc_tx_serializer
// Brief  : HDLC transmitter: flags, zero-stuffed payload and FCS, abort.
// Rev    : 1.0
// ============================================================================
module hdlc_tx_serializer
  import hdlc_tx_pkg::*;
#(
  parameter bit FCS_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_Abort,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_DataValid,
  input  logic       Tx_DataLast,
  output logic       Tx_DataReady,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Underrun,
  output logic       Tx_Done
);

  tx_state_t   r_state;
  logic        r_tx;
  logic        r_valid;
  logic        r_aborted;
  logic        r_underrun;
  logic        r_done;
  logic        r_hold_full;
  logic        r_hold_last;
  logic [7:0]  r_hold_data;
  logic        r_last;
  logic [7:0]  r_shift;
  logic [14:0] r_fcs_sh;
  logic [4:0]  r_bitcnt;
  logic [2:0]  r_ones;

  logic        w_stuff;
  logic        w_need;
  logic        w_underrun;
  logic        w_abort;
  logic        w_take;
  logic        w_fcs_en;
  logic        w_fcs_bit;
  logic        w_fcs_clr;
  logic [15:0] w_fcs;

  // w_need: the last flag bit or last byte bit is on the line and a new byte must follow.
  assign w_stuff    = (r_ones == STUFF_LIMIT);
  assign w_need     = ((r_state == FLAG_START) && (r_bitcnt == 5'd8)) ||
                      ((r_state == DATA) && !w_stuff && (r_bitcnt == 5'd8) && !r_last);
  assign w_underrun = w_need && !r_hold_full;
  assign w_abort    = (Tx_Abort && ((r_state == FLAG_START) || (r_state == DATA) ||
                                    (r_state == FCS))) || w_underrun;
  assign w_take     = w_need && r_hold_full && !Tx_Abort;
  assign w_fcs_en   = w_take ||
                      ((r_state == DATA) && !w_stuff && (r_bitcnt < 5'd8) && !Tx_Abort);
  assign w_fcs_bit  = w_take ? r_hold_data[0] : r_shift[0];
  assign w_fcs_clr  = (r_state == IDLE);

  hdlc_fcs16 u_fcs (
    .clk      (Clk),
    .rst      (Rst),
    .i_clear  (w_fcs_clr),
    .i_enable (w_fcs_en),
    .i_bit    (w_fcs_bit),
    .o_fcs    (w_fcs)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_tx        <= 1'b1;
      r_valid     <= 1'b0;
      r_aborted   <= 1'b0;
      r_underrun  <= 1'b0;
      r_done      <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_hold_data <= 8'h00;
      r_last      <= 1'b0;
      r_shift     <= 8'h00;
      r_fcs_sh    <= 15'h0000;
      r_bitcnt    <= 5'd0;
      r_ones      <= 3'd0;
    end else begin
      r_done <= 1'b0;
      if (Tx_DataValid && !r_hold_full) begin
        r_hold_full <= 1'b1;
        r_hold_data <= Tx_Data;
        r_hold_last <= Tx_DataLast;
      end

      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (Tx_Enable) begin
            r_state    <= FLAG_START;
            r_tx       <= HDLC_FLAG[0];
            r_bitcnt   <= 5'd1;
            r_valid    <= 1'b1;
            r_aborted  <= 1'b0;
            r_underrun <= 1'b0;
            r_ones     <= 3'd0;
          end
        end

        FLAG_START, DATA, FCS: begin
          if (w_abort) begin
            r_state     <= ABORT;
            r_tx        <= HDLC_ABORT[0];
            r_bitcnt    <= 5'd1;
            r_valid     <= 1'b0;
            r_hold_full <= 1'b0;
            r_ones      <= 3'd0;
            if (w_underrun) begin
              r_underrun <= 1'b1;
            end
          end else if (w_take) begin
            r_state     <= DATA;
            r_tx        <= r_hold_data[0];
            r_shift     <= {1'b0, r_hold_data[7:1]};
            r_last      <= r_hold_last;
            r_hold_full <= 1'b0;
            r_bitcnt    <= 5'd1;
            r_ones      <= ones_next(r_ones, r_hold_data[0]);
          end else if (r_state == FLAG_START) begin
            r_tx     <= HDLC_FLAG[r_bitcnt[2:0]];
            r_bitcnt <= r_bitcnt + 5'd1;
          end else if (w_stuff) begin
            // Stuffed zero: shifter and FCS hold for this cycle.
            r_tx   <= 1'b0;
            r_ones <= 3'd0;
          end else if ((r_state == DATA) && (r_bitcnt != 5'd8)) begin
            r_tx     <= r_shift[0];
            r_shift  <= {1'b0, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 5'd1;
            r_ones   <= ones_next(r_ones, r_shift[0]);
          end else if ((r_state == DATA) && FCS_EN) begin
            r_state  <= FCS;
            r_tx     <= w_fcs[0];
            r_fcs_sh <= w_fcs[15:1];
            r_bitcnt <= 5'd1;
            r_ones   <= ones_next(r_ones, w_fcs[0]);
          end else if ((r_state == FCS) && (r_bitcnt != 5'd16)) begin
            r_tx     <= r_fcs_sh[0];
            r_fcs_sh <= {1'b0, r_fcs_sh[14:1]};
            r_bitcnt <= r_bitcnt + 5'd1;
            r_ones   <= ones_next(r_ones, r_fcs_sh[0]);
          end else begin
            r_state  <= FLAG_END;
            r_tx     <= HDLC_FLAG[0];
            r_bitcnt <= 5'd1;
            r_ones   <= 3'd0;
          end
        end

        FLAG_END: begin
          if (r_bitcnt != 5'd8) begin
            r_tx     <= HDLC_FLAG[r_bitcnt[2:0]];
            r_bitcnt <= r_bitcnt + 5'd1;
          end else begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        ABORT: begin
          r_aborted <= 1'b1;
          r_tx      <= HDLC_ABORT[r_bitcnt[2:0]];
          r_bitcnt  <= r_bitcnt + 5'd1;
          if (r_bitcnt == 5'd7) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Tx              = r_tx;
  assign Tx_ValidFrame   = r_valid;
  assign Tx_DataReady    = !r_hold_full;
  assign Tx_AbortedTrans = r_aborted;
  assign Tx_Underrun     = r_underrun;
  assign Tx_Done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hdlc_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_hdlc_tx_serializer
// Brief  : Directed self-checking bench for hdlc_tx_serializer.
// Rev    : 1.0
// ============================================================================
module tb_hdlc_tx_serializer;

  logic       Clk          = 1'b0;
  logic       Rst          = 1'b1;
  logic       Tx_Enable    = 1'b0;
  logic       Tx_Abort     = 1'b0;
  logic [7:0] Tx_Data      = 8'h00;
  logic       Tx_DataValid = 1'b0;
  logic       Tx_DataLast  = 1'b0;
  logic       Tx_DataReady;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Underrun;
  logic       Tx_Done;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int t0       = 0;
  int cs       = 0;
  int d0       = 0;
  int ones     = 0;
  int n        = 0;

  logic        cap_q [$];
  logic [7:0]  exp1 [13] = '{8'h7E, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                             8'h37, 8'h38, 8'h39, 8'h6E, 8'h90, 8'h7E};
  logic [63:0] ev;
  logic [63:0] cv;
  logic [31:0] dv;
  logic [7:0]  fl;
  logic [7:0]  bb;
  logic [7:0]  pat;
  logic        b;

  hdlc_tx_serializer #(.FCS_EN(1'b1)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Tx_Enable       (Tx_Enable),
    .Tx_Abort        (Tx_Abort),
    .Tx_Data         (Tx_Data),
    .Tx_DataValid    (Tx_DataValid),
    .Tx_DataLast     (Tx_DataLast),
    .Tx_DataReady    (Tx_DataReady),
    .Tx              (Tx),
    .Tx_ValidFrame   (Tx_ValidFrame),
    .Tx_AbortedTrans (Tx_AbortedTrans),
    .Tx_Underrun     (Tx_Underrun),
    .Tx_Done         (Tx_Done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Tx_ValidFrame) cap_q.push_back(Tx);
    if (Tx_Done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input int k);
    if (cs + k < cap_q.size()) return cap_q[cs + k];
    return 1'bx;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    Tx_Data      = d;
    Tx_DataLast  = l;
    Tx_DataValid = 1'b1;
    while (!Tx_DataReady && t < 200) begin
      @(negedge Clk);
      t++;
    end
    @(negedge Clk);
    Tx_DataValid = 1'b0;
    Tx_DataLast  = 1'b0;
    chk("byte_accept", 64'(t < 200), 64'(1));
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(negedge Clk);
      t++;
    end
    chk(tag, 64'(t < 400), 64'(1));
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge Clk);
    chk("rst_tx", 64'(Tx), 64'(1));
    chk("rst_valid", 64'(Tx_ValidFrame), 64'(0));
    chk("rst_ready", 64'(Tx_DataReady), 64'(1));
    chk("rst_aborted", 64'(Tx_AbortedTrans), 64'(0));
    chk("rst_underrun", 64'(Tx_Underrun), 64'(0));
    chk("rst_done", 64'(Tx_Done), 64'(0));
    Rst = 1'b0;
    @(negedge Clk);

    // Abort request in IDLE has no effect; line idles high
    Tx_Abort = 1'b1;
    @(negedge Clk);
    Tx_Abort = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("idle_tx_%0d", k), 64'(Tx), 64'(1));
      @(negedge Clk);
    end
    chk("idle_abort_ignored", 64'(Tx_AbortedTrans), 64'(0));
    chk("idle_valid", 64'(Tx_ValidFrame), 64'(0));

    // Frame "123456789" with FCS; stray Tx_Enable mid-frame
    cs = cap_q.size();
    d0 = done_cnt;
    send_byte(8'h31, 1'b0);
    Tx_Enable = 1'b1;
    @(negedge Clk);
    Tx_Enable = 1'b0;
    chk("f1_first_bit", 64'(Tx), 64'(0));
    chk("f1_valid_start", 64'(Tx_ValidFrame), 64'(1));
    for (int i = 1; i < 9; i++) begin
      if (i == 4) begin
        Tx_Enable = 1'b1;
        @(negedge Clk);
        Tx_Enable = 1'b0;
      end
      send_byte(8'(8'h31 + i), (i == 8));
    end
    wait_done("f1_done_seen");
    chk("f1_len", 64'(cap_q.size() - cs), 64'(104));
    for (int k = 0; k < 13; k++) begin
      for (int j = 0; j < 8; j++) bb[j] = bit_at(k * 8 + j);
      chk($sformatf("f1_byte%0d", k), 64'(bb), 64'(exp1[k]));
    end
    chk("f1_done_once", 64'(done_cnt - d0), 64'(1));
    chk("f1_no_abort", 64'(Tx_AbortedTrans), 64'(0));
    chk("f1_idle_tx", 64'(Tx), 64'(1));

    // 0xFF,0xFF: FCS is 0xFFFF too, so 32 ones stuffed every fifth
    cs = cap_q.size();
    d0 = done_cnt;
    send_byte(8'hFF, 1'b0);
    Tx_Enable = 1'b1;
    @(negedge Clk);
    Tx_Enable = 1'b0;
    send_byte(8'hFF, 1'b1);
    wait_done("f2_done_seen");
    chk("f2_len", 64'(cap_q.size() - cs), 64'(54));
    fl = 8'h7E;
    ev = '0;
    cv = '0;
    for (int k = 0; k < 8; k++) begin
      ev[k]      = fl[k];
      ev[46 + k] = fl[k];
    end
    for (int k = 0; k < 38; k++) ev[8 + k] = (k < 36 && (k % 6) == 5) ? 1'b0 : 1'b1;
    for (int k = 0; k < 54; k++) cv[k] = bit_at(k);
    chk("f2_stream", cv, ev);
    ones = 0;
    n    = 0;
    dv   = '0;
    for (int k = 8; k < cap_q.size() - cs - 8; k++) begin
      b = bit_at(k);
      if (ones == 5) begin
        ones = 0;
      end else begin
        if (n < 32) dv[n] = b;
        n++;
        ones = b ? ones + 1 : 0;
      end
    end
    chk("f2_destuff_len", 64'(n), 64'(32));
    chk("f2_payload", 64'(dv[15:0]), 64'(16'hFFFF));
    chk("f2_fcs", 64'(dv[31:16]), 64'(16'hFFFF));
    chk("f2_done_once", 64'(done_cnt - d0), 64'(1));

    // Abort during the second payload byte
    d0 = done_cnt;
    send_byte(8'hA5, 1'b0);
    Tx_Enable = 1'b1;
    @(negedge Clk);
    Tx_Enable = 1'b0;
    t0 = cyc;
    send_byte(8'h3C, 1'b0);
    while (cyc < t0 + 17) @(negedge Clk);
    chk("ab_valid_before", 64'(Tx_ValidFrame), 64'(1));
    Tx_Abort = 1'b1;
    @(negedge Clk);
    Tx_Abort = 1'b0;
    chk("ab_tx_n1", 64'(Tx), 64'(0));
    chk("ab_valid_n1", 64'(Tx_ValidFrame), 64'(0));
    chk("ab_aborted_n1", 64'(Tx_AbortedTrans), 64'(0));
    @(negedge Clk);
    chk("ab_aborted_n2", 64'(Tx_AbortedTrans), 64'(1));
    for (int k = 2; k <= 12; k++) begin
      chk($sformatf("ab_tx_n%0d", k), 64'(Tx), 64'(1));
      @(negedge Clk);
    end
    chk("ab_valid_after", 64'(Tx_ValidFrame), 64'(0));
    chk("ab_aborted_held", 64'(Tx_AbortedTrans), 64'(1));
    chk("ab_underrun", 64'(Tx_Underrun), 64'(0));
    chk("ab_no_done", 64'(done_cnt - d0), 64'(0));

    // Underrun: only the first of three bytes is supplied
    d0 = done_cnt;
    send_byte(8'h11, 1'b0);
    Tx_Enable = 1'b1;
    @(negedge Clk);
    Tx_Enable = 1'b0;
    t0 = cyc;
    chk("ur_aborted_cleared", 64'(Tx_AbortedTrans), 64'(0));
    while (cyc < t0 + 16) @(negedge Clk);
    chk("ur_valid_drop", 64'(Tx_ValidFrame), 64'(0));
    for (int k = 0; k < 8; k++) begin
      pat[k] = Tx;
      @(negedge Clk);
    end
    chk("ur_pattern", 64'(pat), 64'(8'hFE));
    repeat (10) @(negedge Clk);
    chk("ur_underrun", 64'(Tx_Underrun), 64'(1));
    chk("ur_aborted", 64'(Tx_AbortedTrans), 64'(1));
    chk("ur_no_done", 64'(done_cnt - d0), 64'(0));
    chk("ur_idle_tx", 64'(Tx), 64'(1));

    // Asynchronous reset clears sticky status immediately
    #2 Rst = 1'b1;
    #1;
    chk("rs1_aborted", 64'(Tx_AbortedTrans), 64'(0));
    chk("rs1_underrun", 64'(Tx_Underrun), 64'(0));
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // Asynchronous reset in the middle of a frame
    send_byte(8'h55, 1'b0);
    Tx_Enable = 1'b1;
    @(negedge Clk);
    Tx_Enable = 1'b0;
    chk("rs2_pre_tx", 64'(Tx), 64'(0));
    chk("rs2_pre_ready", 64'(Tx_DataReady), 64'(0));
    #2 Rst = 1'b1;
    #1;
    chk("rs2_tx", 64'(Tx), 64'(1));
    chk("rs2_valid", 64'(Tx_ValidFrame), 64'(0));
    chk("rs2_ready", 64'(Tx_DataReady), 64'(1));
    chk("rs2_done", 64'(Tx_Done), 64'(0));
    @(negedge Clk);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rs2_idle_tx", 64'(Tx), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
